// File: rtl/amiga_eclk_cycle.sv
// amiga_eclk_cycle
//
// Purpose:
//   Sequences a 6800-style synchronous peripheral cycle (CIA bus) on the
//   28 MHz domain. A CPU request is aligned to the 0.709 MHz E clock derived
//   from the one-hot eclk phase supplied by the clock generator. VMA is
//   asserted from the count 4 sample to the count 9 sample, and the transfer
//   strobe and a one-cycle acknowledge are issued at the E falling point.
//
// Ports:
//   clk_28      in   28 MHz clock, all flops on its rising edge
//   rst         in   synchronous active-high reset
//   clk7_en     in   7 MHz enable; a cycle with clk7_en=1 is a "sample"
//   eclk[9:0]   in   one-hot E phase; non-one-hot values mean "no count"
//   req         in   CPU request level, held until ack
//   we          in   write when 1, latched when the request is accepted
//   wdata[7:0]  in   write data, latched when the request is accepted
//   rdata[7:0]  out  read data, valid from ack onward
//   ack         out  one-cycle completion pulse
//   err         out  watchdog abort flag, pulses with ack
//   vma         out  valid memory address
//   e           out  E clock level
//   per_sel     out  peripheral select (coincident with vma)
//   per_we      out  peripheral write enable
//   per_wdata   out  peripheral write data
//   per_strobe  out  one-cycle transfer strobe at the E falling point
//   per_rdata   in   peripheral read data, captured at the count 9 sample
//
// Configuration:
//   AMIGA_ECLK_TIMEOUT_EN  when defined, a watchdog aborts a request that
//                          waits TMO_SAMPLES samples in SYNC without seeing
//                          count 4 (ack+err, rdata=0xFF). When undefined,
//                          err is tied low and SYNC waits indefinitely.

module amiga_eclk_cycle #(
  parameter int TMO_SAMPLES = 12
) (
  input  logic       clk_28,
  input  logic       rst,
  input  logic       clk7_en,
  input  logic [9:0] eclk,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       err,
  output logic       vma,
  output logic       e,
  output logic       per_sel,
  output logic       per_we,
  output logic [7:0] per_wdata,
  output logic       per_strobe,
  input  logic [7:0] per_rdata
);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

  state_t     state;
  logic       we_lat;
  logic [7:0] wdata_lat;

  // A phase only counts when exactly one eclk bit is set; clearing the
  // lowest set bit leaves zero only for a one-hot value.
  logic onehot;
  logic cnt4, cnt5, cnt9;

  assign onehot = (eclk != 10'd0) && ((eclk & (eclk - 10'd1)) == 10'd0);
  assign cnt4   = clk7_en && onehot && eclk[4];
  assign cnt5   = clk7_en && onehot && eclk[5];
  assign cnt9   = clk7_en && onehot && eclk[9];

`ifdef AMIGA_ECLK_TIMEOUT_EN
  localparam int TW = $clog2(TMO_SAMPLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // The watchdog fires on the sample that would be the TMO_SAMPLES-th one
  // spent waiting in SYNC with the request still held.
  assign tmo_hit = (tmo_cnt == TW'(TMO_SAMPLES - 1));
`else
  assign err = 1'b0;
`endif

  // Single sequencer: ack/per_strobe/err are one-cycle pulses defaulting low;
  // the E level free-runs from the phase regardless of the bus state.
  always_ff @(posedge clk_28) begin
    if (rst) begin
      state      <= IDLE;
      we_lat     <= 1'b0;
      wdata_lat  <= 8'h00;
      rdata      <= 8'h00;
      ack        <= 1'b0;
      vma        <= 1'b0;
      e          <= 1'b0;
      per_sel    <= 1'b0;
      per_we     <= 1'b0;
      per_wdata  <= 8'h00;
      per_strobe <= 1'b0;
`ifdef AMIGA_ECLK_TIMEOUT_EN
      err        <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      ack        <= 1'b0;
      per_strobe <= 1'b0;
`ifdef AMIGA_ECLK_TIMEOUT_EN
      err        <= 1'b0;
      if (state == SYNC && clk7_en && req && !cnt4)
        tmo_cnt <= tmo_cnt + TW'(1);
      else if (state != SYNC)
        tmo_cnt <= '0;
`endif

      if (cnt5)
        e <= 1'b1;
      else if (cnt9)
        e <= 1'b0;

      case (state)
        IDLE: begin
          if (clk7_en && req) begin
            we_lat    <= we;
            wdata_lat <= wdata;
            // Request already aligned: drive the bus from the live inputs
            // since the latch is only being loaded this same edge.
            if (cnt4) begin
              vma       <= 1'b1;
              per_sel   <= 1'b1;
              per_we    <= we;
              per_wdata <= wdata;
              state     <= ACTIVE;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (clk7_en) begin
            if (!req) begin
              state <= IDLE;
            end else if (cnt4) begin
              vma       <= 1'b1;
              per_sel   <= 1'b1;
              per_we    <= we_lat;
              per_wdata <= wdata_lat;
              state     <= ACTIVE;
            end
`ifdef AMIGA_ECLK_TIMEOUT_EN
            else if (tmo_hit) begin
              ack   <= 1'b1;
              err   <= 1'b1;
              rdata <= 8'hFF;
              state <= DONE;
            end
`endif
          end
        end

        ACTIVE: begin
          // req is deliberately ignored: a VMA cycle always runs to the end.
          if (cnt9) begin
            per_strobe <= 1'b1;
            ack        <= 1'b1;
            if (!we_lat)
              rdata <= per_rdata;
            vma     <= 1'b0;
            per_sel <= 1'b0;
            per_we  <= 1'b0;
            state   <= DONE;
          end
        end

        DONE: begin
          if (!req)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amiga_eclk_cycle.sv
// tb_amiga_eclk_cycle
//
// Self-checking bench for amiga_eclk_cycle. A free-running generator
// produces clk7_en (every 4th clk_28 cycle) and the one-hot E phase. Tests
// launch requests at a chosen E count and predict event times from the
// E-clock arithmetic: a request first seen at count k waits (14-k)%10
// samples for count 4, VMA then lasts 5 samples, and everything registered
// appears one cycle after the deciding sample.
// Honours AMIGA_ECLK_TIMEOUT_EN for the watchdog scenario.

module tb_amiga_eclk_cycle;

  localparam int TMO = 12;

  logic       clk_28 = 1'b0;
  logic       rst;
  logic       clk7_en;
  logic [9:0] eclk;
  logic       req;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic       err;
  logic       vma;
  logic       e;
  logic       per_sel;
  logic       per_we;
  logic [7:0] per_wdata;
  logic       per_strobe;
  logic [7:0] per_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sc = 0;
  int ecount = 0;
  int eclk_mode = 0;
  logic [7:0] rdata_model = 8'h00;

  typedef struct {
    int first_vma;
    int vma_cycles;
    int first_ack;
    int ack_count;
    int strobe_count;
    int strobe_off_ack;
    int e_rise;
    int e_fall;
    int err_count;
    int bad_we;
    int bad_wdata;
    int bad_sel;
    logic [7:0] rdata_ack;
  } mon_t;

  amiga_eclk_cycle #(.TMO_SAMPLES(TMO)) dut (
    .clk_28    (clk_28),
    .rst       (rst),
    .clk7_en   (clk7_en),
    .eclk      (eclk),
    .req       (req),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .vma       (vma),
    .e         (e),
    .per_sel   (per_sel),
    .per_we    (per_we),
    .per_wdata (per_wdata),
    .per_strobe(per_strobe),
    .per_rdata (per_rdata)
  );

  always #5 clk_28 = ~clk_28;

  function automatic logic [9:0] make_eclk(input int mode, input int cnt);
    logic [9:0] one;
    one = 10'd1 << cnt;
    case (mode)
      1:       return 10'd0;
      2:       return one | 10'h210;
      default: return one;
    endcase
  endfunction

  // Phase generator: updates shortly after each rising edge so the values
  // seen at a negedge are exactly what the next rising edge will sample.
  initial begin
    clk7_en = 1'b1;
    eclk    = make_eclk(0, 0);
    forever begin
      @(posedge clk_28);
      cyc++;
      #2;
      sc = (sc + 1) % 4;
      if (sc == 0) ecount = (ecount + 1) % 10;
      clk7_en = (sc == 0);
      eclk    = make_eclk(eclk_mode, ecount);
    end
  end

  // Observes outputs at each negedge for ncyc cycles and summarises them.
  task automatic run_monitor(input int ncyc, input int drop_at, input bit drop_on_ack,
                             input logic exp_we, input logic [7:0] exp_wdata,
                             output mon_t r);
    logic prev_e;
    r.first_vma = -1; r.vma_cycles = 0; r.first_ack = -1; r.ack_count = 0;
    r.strobe_count = 0; r.strobe_off_ack = 0; r.e_rise = -1; r.e_fall = -1;
    r.err_count = 0; r.bad_we = 0; r.bad_wdata = 0; r.bad_sel = 0;
    r.rdata_ack = 8'h00;
    prev_e = e;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk_28);
      if (vma === 1'b1) begin
        if (r.first_vma < 0) r.first_vma = cyc;
        r.vma_cycles++;
        if (per_we !== exp_we) r.bad_we++;
        if (per_wdata !== exp_wdata) r.bad_wdata++;
      end
      if (per_sel !== vma) r.bad_sel++;
      if (ack === 1'b1) begin
        r.ack_count++;
        if (r.first_ack < 0) begin
          r.first_ack = cyc;
          r.rdata_ack = rdata;
        end
        if (drop_on_ack) req = 1'b0;
      end
      if (per_strobe === 1'b1) r.strobe_count++;
      if (per_strobe !== ack) r.strobe_off_ack++;
      if (err === 1'b1) r.err_count++;
      if (r.first_vma >= 0 && e === 1'b1 && prev_e !== 1'b1 && r.e_rise < 0) r.e_rise = cyc;
      if (r.e_rise >= 0 && e === 1'b0 && prev_e === 1'b1 && r.e_fall < 0) r.e_fall = cyc;
      prev_e = e;
      if (cyc == drop_at) req = 1'b0;
    end
  endtask

  // Waits (bounded) for the negedge before a count k sample, then raises req.
  // n0 is the cycle number of the sample that first sees the request.
  task automatic launch(input int k, output int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk_28);
      if (clk7_en && ecount == k) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL launch_wait: count %0d not reached within 60 cycles", k);
    end
    req = 1'b1;
    n0  = cyc + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; wdata = 8'h00; per_rdata = 8'h00;
    repeat (4) @(negedge clk_28);
    checks++;
    if ({e, vma, ack, err, per_sel, per_we, per_strobe} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {e, vma, ack, err, per_sel, per_we, per_strobe});
    end
    checks++;
    if ({rdata, per_wdata} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h expected 0000", {rdata, per_wdata});
    end
    rst = 1'b0;
    rdata_model = 8'h00;
    repeat (2) @(negedge clk_28);
  endtask

  task automatic test_read();
    int n0;
    mon_t r;
    we = 1'b0; wdata = 8'h96; per_rdata = 8'h5A;
    launch(4, n0);
    run_monitor(30, -1, 1'b1, 1'b0, 8'h96, r);
    checks++; if (r.first_vma !== n0) begin errors++;
      $display("[TB] FAIL read_vma_rise: got %0d expected %0d", r.first_vma, n0); end
    checks++; if (r.vma_cycles !== 20) begin errors++;
      $display("[TB] FAIL read_vma_len: got %0d expected 20", r.vma_cycles); end
    checks++; if (r.e_rise !== n0 + 4 || r.e_fall !== n0 + 20) begin errors++;
      $display("[TB] FAIL read_e_window: got %0d/%0d expected %0d/%0d",
               r.e_rise, r.e_fall, n0 + 4, n0 + 20); end
    checks++; if (r.first_ack !== n0 + 20 || r.ack_count !== 1) begin errors++;
      $display("[TB] FAIL read_ack: got at %0d x%0d expected at %0d x1",
               r.first_ack, r.ack_count, n0 + 20); end
    checks++; if (r.strobe_count !== 1 || r.strobe_off_ack !== 0) begin errors++;
      $display("[TB] FAIL read_strobe: got %0d strobes %0d misaligned expected 1/0",
               r.strobe_count, r.strobe_off_ack); end
    checks++; if (r.rdata_ack !== 8'h5A) begin errors++;
      $display("[TB] FAIL read_rdata: got %h expected 5a", r.rdata_ack); end
    checks++; if (r.bad_we !== 0 || r.bad_wdata !== 0 || r.bad_sel !== 0) begin errors++;
      $display("[TB] FAIL read_bus: got we/wdata/sel errs %0d/%0d/%0d expected 0",
               r.bad_we, r.bad_wdata, r.bad_sel); end
    rdata_model = 8'h5A;
    @(negedge clk_28);
  endtask

  task automatic test_write();
    int n0;
    mon_t r;
    we = 1'b1; wdata = 8'hC3; per_rdata = 8'h11;
    launch(5, n0);
    run_monitor(62, -1, 1'b1, 1'b1, 8'hC3, r);
    checks++; if (r.first_vma !== n0 + 36) begin errors++;
      $display("[TB] FAIL write_vma_rise: got %0d expected %0d", r.first_vma, n0 + 36); end
    checks++; if (r.first_ack !== n0 + 56 || r.ack_count !== 1) begin errors++;
      $display("[TB] FAIL write_ack: got at %0d x%0d expected at %0d x1",
               r.first_ack, r.ack_count, n0 + 56); end
    checks++; if (r.vma_cycles !== 20 || r.bad_we !== 0 || r.bad_wdata !== 0) begin errors++;
      $display("[TB] FAIL write_bus: got len %0d we errs %0d wdata errs %0d expected 20/0/0",
               r.vma_cycles, r.bad_we, r.bad_wdata); end
    checks++; if (r.strobe_count !== 1) begin errors++;
      $display("[TB] FAIL write_strobe: got %0d expected 1", r.strobe_count); end
    checks++; if (r.rdata_ack !== rdata_model || rdata !== rdata_model) begin errors++;
      $display("[TB] FAIL write_rdata_kept: got %h expected %h", rdata, rdata_model); end
    @(negedge clk_28);
  endtask

  task automatic test_sync_abandon();
    int n0;
    mon_t r;
    we = 1'b0;
    launch(7, n0);
    run_monitor(70, n0 + 6, 1'b0, 1'b0, wdata, r);
    checks++; if (r.first_vma !== -1 || r.ack_count !== 0) begin errors++;
      $display("[TB] FAIL sync_abandon: got vma at %0d acks %0d expected none",
               r.first_vma, r.ack_count); end
  endtask

  task automatic test_active_drop();
    int n0;
    mon_t r;
    we = 1'b0; per_rdata = 8'hA7;
    launch(4, n0);
    run_monitor(30, n0 + 8, 1'b0, 1'b0, wdata, r);
    checks++; if (r.first_ack !== n0 + 20 || r.ack_count !== 1 || r.vma_cycles !== 20) begin
      errors++;
      $display("[TB] FAIL active_drop: got ack at %0d x%0d vma %0d expected at %0d x1 vma 20",
               r.first_ack, r.ack_count, r.vma_cycles, n0 + 20); end
    rdata_model = 8'hA7;
    @(negedge clk_28);
  endtask

  task automatic test_hold_after_ack();
    int n0;
    mon_t r;
    we = 1'b0; per_rdata = 8'h3C;
    launch(4, n0);
    run_monitor(110, -1, 1'b0, 1'b0, wdata, r);
    checks++; if (r.ack_count !== 1 || r.vma_cycles !== 20) begin errors++;
      $display("[TB] FAIL hold_after_ack: got acks %0d vma %0d expected 1/20",
               r.ack_count, r.vma_cycles); end
    rdata_model = 8'h3C;
    req = 1'b0;
    repeat (2) @(negedge clk_28);
  endtask

  task automatic test_reset_mid_active();
    int n0;
    mon_t r;
    we = 1'b1; wdata = 8'h44;
    launch(4, n0);
    run_monitor(8, -1, 1'b0, 1'b1, 8'h44, r);
    checks++; if (r.vma_cycles !== 8) begin errors++;
      $display("[TB] FAIL rst_active_pre: got vma %0d cycles expected 8", r.vma_cycles); end
    rst = 1'b1; req = 1'b0;
    @(negedge clk_28);
    checks++;
    if ({e, vma, ack, err, per_sel, per_we, per_strobe, rdata, per_wdata} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL rst_active_outputs: got %h expected 0",
               {e, vma, ack, err, per_sel, per_we, per_strobe, rdata, per_wdata});
    end
    rst = 1'b0;
    rdata_model = 8'h00;
    run_monitor(60, -1, 1'b0, 1'b0, 8'h00, r);
    checks++; if (r.ack_count !== 0 || r.first_vma !== -1) begin errors++;
      $display("[TB] FAIL rst_active_no_ack: got acks %0d vma at %0d expected none",
               r.ack_count, r.first_vma); end
  endtask

  task automatic test_random();
    int n0, k, w;
    mon_t r;
    logic [7:0] prd, exp_rd;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 9);
      w = (14 - k) % 10;
      we = 1'($urandom);
      wdata = 8'($urandom);
      prd = 8'($urandom);
      per_rdata = prd;
      repeat ($urandom_range(0, 5)) @(negedge clk_28);
      launch(k, n0);
      run_monitor(4 * w + 26, -1, 1'b1, we, wdata, r);
      exp_rd = we ? rdata_model : prd;
      checks++; if (r.first_vma !== n0 + 4 * w || r.vma_cycles !== 20) begin errors++;
        $display("[TB] FAIL rand_vma k=%0d: got at %0d len %0d expected at %0d len 20",
                 k, r.first_vma, r.vma_cycles, n0 + 4 * w); end
      checks++; if (r.first_ack !== n0 + 4 * w + 20 || r.ack_count !== 1) begin errors++;
        $display("[TB] FAIL rand_ack k=%0d: got at %0d x%0d expected at %0d x1",
                 k, r.first_ack, r.ack_count, n0 + 4 * w + 20); end
      checks++; if (r.rdata_ack !== exp_rd) begin errors++;
        $display("[TB] FAIL rand_rdata k=%0d we=%0b: got %h expected %h",
                 k, we, r.rdata_ack, exp_rd); end
      checks++; if (r.bad_we !== 0 || r.bad_wdata !== 0 || r.bad_sel !== 0 ||
                    r.strobe_count !== 1 || r.strobe_off_ack !== 0) begin errors++;
        $display("[TB] FAIL rand_bus k=%0d: got we/wd/sel/strobe/off %0d/%0d/%0d/%0d/%0d expected 0/0/0/1/0",
                 k, r.bad_we, r.bad_wdata, r.bad_sel, r.strobe_count, r.strobe_off_ack); end
      checks++; if (r.e_rise !== r.first_vma + 4 || r.e_fall !== r.first_vma + 20) begin errors++;
        $display("[TB] FAIL rand_e k=%0d: got %0d/%0d expected %0d/%0d",
                 k, r.e_rise, r.e_fall, r.first_vma + 4, r.first_vma + 20); end
      rdata_model = exp_rd;
      @(negedge clk_28);
    end
  endtask

  task automatic test_timeout();
    int n0;
    mon_t r;
    for (int m = 1; m <= 2; m++) begin
      eclk_mode = m;
      we = 1'b0;
      launch(0, n0);
`ifdef AMIGA_ECLK_TIMEOUT_EN
      run_monitor(4 * TMO + 10, -1, 1'b1, 1'b0, wdata, r);
      checks++; if (r.first_ack !== n0 + 4 * TMO || r.ack_count !== 1) begin errors++;
        $display("[TB] FAIL timeout_ack mode=%0d: got at %0d x%0d expected at %0d x1",
                 m, r.first_ack, r.ack_count, n0 + 4 * TMO); end
      checks++; if (r.err_count !== 1 || r.rdata_ack !== 8'hFF || r.first_vma !== -1) begin
        errors++;
        $display("[TB] FAIL timeout_err mode=%0d: got err %0d rdata %h vma at %0d expected 1/ff/none",
                 m, r.err_count, r.rdata_ack, r.first_vma); end
      rdata_model = 8'hFF;
`else
      run_monitor(420, -1, 1'b0, 1'b0, wdata, r);
      checks++; if (r.ack_count !== 0 || r.err_count !== 0 || r.first_vma !== -1) begin errors++;
        $display("[TB] FAIL no_timeout mode=%0d: got acks %0d errs %0d vma at %0d expected none",
                 m, r.ack_count, r.err_count, r.first_vma); end
      req = 1'b0;
`endif
      repeat (8) @(negedge clk_28);
      eclk_mode = 0;
      repeat (8) @(negedge clk_28);
    end
    checks++; if (rdata !== rdata_model) begin errors++;
      $display("[TB] FAIL timeout_rdata_final: got %h expected %h", rdata, rdata_model); end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; wdata = 8'h00; per_rdata = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_sync_abandon();
    test_active_drop();
    test_hold_after_ack();
    test_reset_mid_active();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
